// File: rtl/rob_ring_commit_if.sv
// Bundle of dispatch, writeback, flush and retire signals between the pipeline and the ROB.
// The wb_exc/exc_valid/exc_idx signals exist only when ROB_EXCEPTION_EN is defined.
interface rob_ring_commit_if #(
    parameter int ROB_ENTRIES            = 16,
    parameter int DISPATCH_WIDTH         = 2,
    parameter int COMMIT_WIDTH           = 2,
    parameter int WB_PORTS               = 2,
    parameter int NUM_AREGS              = 16,
    parameter int NUM_PREGS              = 64,
    parameter int MAX_PREDICT_DEPTH_BITS = 2
);
    localparam int IW   = $clog2(ROB_ENTRIES);
    localparam int AW   = $clog2(NUM_AREGS);
    localparam int PW   = $clog2(NUM_PREGS);
    localparam int CNTW = $clog2(DISPATCH_WIDTH + 1);
    localparam int TW   = MAX_PREDICT_DEPTH_BITS;

    logic                         clear;
    logic [CNTW-1:0]              disp_count;
    logic [DISPATCH_WIDTH*AW-1:0] disp_areg;
    logic [DISPATCH_WIDTH*PW-1:0] disp_preg;
    logic [DISPATCH_WIDTH-1:0]    disp_zerocycle;
    logic [DISPATCH_WIDTH*TW-1:0] disp_tag;
    logic                         disp_stall;
    logic [DISPATCH_WIDTH*IW-1:0] disp_idx;
    logic [WB_PORTS-1:0]          wb_valid;
    logic [WB_PORTS*IW-1:0]       wb_idx;
    logic                         flush_valid;
    logic [TW-1:0]                flush_tag;
    logic [COMMIT_WIDTH-1:0]      commit_valid;
    logic [COMMIT_WIDTH*AW-1:0]   commit_areg;
    logic [COMMIT_WIDTH*PW-1:0]   commit_preg;
    logic [COMMIT_WIDTH-1:0]      free_valid;
    logic [COMMIT_WIDTH*PW-1:0]   free_addr;
    logic                         fl_shootdown;
    logic [TW-1:0]                fl_shootdown_tag;
`ifdef ROB_EXCEPTION_EN
    logic [WB_PORTS-1:0]          wb_exc;
    logic                         exc_valid;
    logic [IW-1:0]                exc_idx;
`endif

    modport master (
        output clear, disp_count, disp_areg, disp_preg, disp_zerocycle, disp_tag,
        output wb_valid, wb_idx, flush_valid, flush_tag,
`ifdef ROB_EXCEPTION_EN
        output wb_exc,
        input  exc_valid, exc_idx,
`endif
        input  disp_stall, disp_idx, commit_valid, commit_areg, commit_preg,
        input  free_valid, free_addr, fl_shootdown, fl_shootdown_tag
    );

    modport slave (
        input  clear, disp_count, disp_areg, disp_preg, disp_zerocycle, disp_tag,
        input  wb_valid, wb_idx, flush_valid, flush_tag,
`ifdef ROB_EXCEPTION_EN
        input  wb_exc,
        output exc_valid, exc_idx,
`endif
        output disp_stall, disp_idx, commit_valid, commit_areg, commit_preg,
        output free_valid, free_addr, fl_shootdown, fl_shootdown_tag
    );
endinterface

// File: rtl/rob_ring_commit.sv
// Circular reorder buffer: in-order dispatch/retire, committed RAT, tag squash.
// Define ROB_EXCEPTION_EN to add precise-exception tracking (wb_exc/exc_valid/exc_idx).
module rob_ring_commit #(
    parameter int ROB_ENTRIES            = 16,
    parameter int DISPATCH_WIDTH         = 2,
    parameter int COMMIT_WIDTH           = 2,
    parameter int WB_PORTS               = 2,
    parameter int NUM_AREGS              = 16,
    parameter int NUM_PREGS              = 64,
    parameter int MAX_PREDICT_DEPTH_BITS = 2
) (
    input logic              clk,
    input logic              reset_n,
    rob_ring_commit_if.slave rob
);
    localparam int IW   = $clog2(ROB_ENTRIES);
    localparam int AW   = $clog2(NUM_AREGS);
    localparam int PW   = $clog2(NUM_PREGS);
    localparam int TW   = MAX_PREDICT_DEPTH_BITS;
    localparam int PTRW = IW + 1;

    // Pointers carry a wrap bit so full (count==ROB_ENTRIES) differs from empty.
    logic [PTRW-1:0]        head_reg, tail_reg, head_next, tail_next;
    logic [ROB_ENTRIES-1:0] valid_reg, busy_reg, valid_next, busy_next;
    logic [ROB_ENTRIES-1:0] exc_mask;
    logic [TW-1:0]          tag_mem  [ROB_ENTRIES];
    logic [AW-1:0]          areg_mem [ROB_ENTRIES];
    logic [PW-1:0]          preg_mem [ROB_ENTRIES];
    logic [PW-1:0]          rat_reg  [NUM_AREGS];

    logic [IW-1:0]   head_idx, tail_idx;
    logic [PTRW-1:0] count, free_cnt, ret_cnt, surv_cnt;
    logic            disp_stall, disp_acc, flush_act, exc_take;

    logic [IW-1:0]           d_idx [DISPATCH_WIDTH];
    logic [IW-1:0]           w_idx [WB_PORTS];
    logic [IW-1:0]           c_idx [COMMIT_WIDTH];
    logic [AW-1:0]           c_areg [COMMIT_WIDTH];
    logic [PW-1:0]           c_preg [COMMIT_WIDTH];
    logic [PW-1:0]           c_old  [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] c_ready, c_ret;
    logic [ROB_ENTRIES-1:0]  ret_mask;

    logic [COMMIT_WIDTH-1:0]    commit_valid_reg, free_valid_reg;
    logic [COMMIT_WIDTH*AW-1:0] commit_areg_reg;
    logic [COMMIT_WIDTH*PW-1:0] commit_preg_reg, free_addr_reg;
    logic                       fl_shootdown_reg;
    logic [TW-1:0]              fl_shootdown_tag_reg;

    assign head_idx = head_reg[IW-1:0];
    assign tail_idx = tail_reg[IW-1:0];
    assign count    = tail_reg - head_reg;
    assign free_cnt = PTRW'(ROB_ENTRIES) - count;

    assign disp_stall = PTRW'(rob.disp_count) > free_cnt;
    assign flush_act  = rob.flush_valid && (rob.flush_tag != '0) && !rob.clear;
    assign disp_acc   = !disp_stall && (rob.disp_count != '0) && !rob.clear
                        && !flush_act && !exc_take;

    for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_disp
        assign d_idx[gi] = tail_idx + IW'(gi);
        assign rob.disp_idx[gi*IW +: IW] = d_idx[gi];
    end

    for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb
        assign w_idx[gi] = rob.wb_idx[gi*IW +: IW];
    end

    for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit
        assign c_idx[gi]   = head_idx + IW'(gi);
        assign c_areg[gi]  = areg_mem[c_idx[gi]];
        assign c_preg[gi]  = preg_mem[c_idx[gi]];
        assign c_ready[gi] = valid_reg[c_idx[gi]] && !busy_reg[c_idx[gi]]
                             && !exc_mask[c_idx[gi]];
    end

    // An excepting entry at head flushes the whole window instead of retiring.
    assign exc_take = valid_reg[head_idx] && exc_mask[head_idx];

    // Retire only the unbroken ready prefix starting at head.
    always_comb begin
        logic run;
        run      = 1'b1;
        c_ret    = '0;
        ret_mask = '0;
        ret_cnt  = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            run      = run & c_ready[s];
            c_ret[s] = run;
            if (run) begin
                ret_mask[c_idx[s]] = 1'b1;
                ret_cnt            = ret_cnt + PTRW'(1);
            end
        end
    end

    // Old mapping: an earlier same-group retiree of the same areg shadows the RAT.
    always_comb begin
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            c_old[s] = rat_reg[c_areg[s]];
            for (int p = 0; p < s; p++) begin
                if (c_ret[p] && (c_areg[p] == c_areg[s]))
                    c_old[s] = c_preg[p];
            end
        end
    end

    // Survivors of a squash are contiguous from the new head because tags grow with age.
    always_comb begin
        surv_cnt = '0;
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            if (valid_reg[i] && !ret_mask[i] && (tag_mem[i] < rob.flush_tag))
                surv_cnt = surv_cnt + PTRW'(1);
        end
    end

    assign head_next = head_reg + ret_cnt;

    always_comb begin
        tail_next = tail_reg;
        if (rob.clear || exc_take)
            tail_next = head_next;
        else if (flush_act)
            tail_next = head_next + surv_cnt;
        else if (disp_acc)
            tail_next = tail_reg + PTRW'(rob.disp_count);
    end

`ifdef ROB_EXCEPTION_EN
    logic [ROB_ENTRIES-1:0] exc_reg, exc_next;
    logic                   exc_valid_reg;
    logic [IW-1:0]          exc_idx_reg;

    assign exc_mask      = exc_reg;
    assign rob.exc_valid = exc_valid_reg;
    assign rob.exc_idx   = exc_idx_reg;
`else
    assign exc_mask = '0;
`endif

    always_comb begin
        valid_next = valid_reg & ~ret_mask;
        busy_next  = busy_reg;
`ifdef ROB_EXCEPTION_EN
        exc_next   = exc_reg;
`endif
        for (int k = 0; k < WB_PORTS; k++) begin
            if (rob.wb_valid[k] && valid_reg[w_idx[k]]) begin
                busy_next[w_idx[k]] = 1'b0;
`ifdef ROB_EXCEPTION_EN
                if (rob.wb_exc[k])
                    exc_next[w_idx[k]] = 1'b1;
`endif
            end
        end
        if (rob.clear || exc_take) begin
            valid_next = '0;
        end else if (flush_act) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                if (valid_reg[i] && (tag_mem[i] >= rob.flush_tag))
                    valid_next[i] = 1'b0;
            end
        end else if (disp_acc) begin
            // Written after writeback so a colliding dispatch wins.
            for (int d = 0; d < DISPATCH_WIDTH; d++) begin
                if (d < int'(rob.disp_count)) begin
                    valid_next[d_idx[d]] = 1'b1;
                    busy_next[d_idx[d]]  = !rob.disp_zerocycle[d];
`ifdef ROB_EXCEPTION_EN
                    exc_next[d_idx[d]]   = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            valid_reg <= '0;
            busy_reg  <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_reg   <= '0;
`endif
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
`ifdef ROB_EXCEPTION_EN
            exc_reg   <= exc_next;
`endif
        end
    end

    // Payload is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (disp_acc) begin
            for (int d = 0; d < DISPATCH_WIDTH; d++) begin
                if (d < int'(rob.disp_count)) begin
                    areg_mem[d_idx[d]] <= rob.disp_areg[d*AW +: AW];
                    preg_mem[d_idx[d]] <= rob.disp_preg[d*PW +: PW];
                    tag_mem[d_idx[d]]  <= rob.disp_tag[d*TW +: TW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < NUM_AREGS; a++)
                rat_reg[a] <= '0;
            commit_valid_reg     <= '0;
            commit_areg_reg      <= '0;
            commit_preg_reg      <= '0;
            free_valid_reg       <= '0;
            free_addr_reg        <= '0;
            fl_shootdown_reg     <= 1'b0;
            fl_shootdown_tag_reg <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_valid_reg        <= 1'b0;
            exc_idx_reg          <= '0;
`endif
        end else begin
            // Loop order gives last-writer-wins for same-areg retirees.
            for (int s = 0; s < COMMIT_WIDTH; s++) begin
                if (c_ret[s])
                    rat_reg[c_areg[s]] <= c_preg[s];
                commit_valid_reg[s]        <= c_ret[s];
                commit_areg_reg[s*AW +: AW] <= c_ret[s] ? c_areg[s] : '0;
                commit_preg_reg[s*PW +: PW] <= c_ret[s] ? c_preg[s] : '0;
                free_valid_reg[s]          <= c_ret[s] && (c_old[s] != '0);
                free_addr_reg[s*PW +: PW]   <= (c_ret[s] && (c_old[s] != '0)) ? c_old[s] : '0;
            end
            fl_shootdown_reg     <= flush_act;
            fl_shootdown_tag_reg <= flush_act ? rob.flush_tag : '0;
`ifdef ROB_EXCEPTION_EN
            exc_valid_reg        <= exc_take;
            exc_idx_reg          <= exc_take ? head_idx : '0;
`endif
        end
    end

    assign rob.disp_stall       = disp_stall;
    assign rob.commit_valid     = commit_valid_reg;
    assign rob.commit_areg      = commit_areg_reg;
    assign rob.commit_preg      = commit_preg_reg;
    assign rob.free_valid       = free_valid_reg;
    assign rob.free_addr        = free_addr_reg;
    assign rob.fl_shootdown     = fl_shootdown_reg;
    assign rob.fl_shootdown_tag = fl_shootdown_tag_reg;
endmodule

// File: tb/tb_rob_ring_commit.sv
// Directed bench for rob_ring_commit: cycle-vector table plus hand sequences for
// reset, full/wrap, tag squash and (with ROB_EXCEPTION_EN) exception flush.
module tb_rob_ring_commit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rob_ring_commit_if rif ();

    rob_ring_commit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rob     (rif)
    );

    // One record per clock: inputs held for the cycle, expectations sampled after the edge.
    typedef struct {
        int clr, dc, a0, a1, p0, p1, zc, t0, t1;
        int wbv, w0, w1, fv, ft;
        int cv, fvl, fa0, fa1, cp0, cp1, didx, fl, flt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk6(input int lo, input int hi);
        return 32'((hi << 6) | lo);
    endfunction

    function automatic logic [31:0] didx_pk(input int d);
        return 32'((((d + 1) % 16) << 4) | d);
    endfunction

    task automatic idle_in();
        rif.clear          = 1'b0;
        rif.disp_count     = '0;
        rif.disp_areg      = '0;
        rif.disp_preg      = '0;
        rif.disp_zerocycle = '0;
        rif.disp_tag       = '0;
        rif.wb_valid       = '0;
        rif.wb_idx         = '0;
        rif.flush_valid    = 1'b0;
        rif.flush_tag      = '0;
`ifdef ROB_EXCEPTION_EN
        rif.wb_exc         = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input int n, input int zc, input int t0, input int t1, input int base);
        rif.disp_count     = 2'(n);
        rif.disp_zerocycle = 2'(zc);
        rif.disp_tag       = {2'(t1), 2'(t0)};
        rif.disp_areg      = {4'(base + 1), 4'(base)};
        rif.disp_preg      = {6'(base + 33), 6'(base + 32)};
    endtask

    task automatic wb2(input int v, input int i0, input int i1);
        rif.wb_valid = 2'(v);
        rif.wb_idx   = {4'(i1), 4'(i0)};
    endtask

    task automatic do_reset();
        idle_in();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        //           clr dc a0 a1 p0 p1 zc t0 t1 wbv w0 w1 fv ft  cv fvl fa0 fa1 cp0 cp1 didx fl flt
        vecs[0]  = '{0, 2, 3, 3, 5, 6, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  2, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 2,  0,  5,  5,  6,  2, 0, 0};
        vecs[2]  = '{0, 1, 3, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  3, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1,  6,  0,  9,  0,  3, 0, 0};
        vecs[4]  = '{0, 2, 1, 2,10,11, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  5, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  5, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 0,  0,  0,  0,  0,  5, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0,  0,  0, 10, 11,  5, 0, 0};
        vecs[8]  = '{0, 2, 6, 7,20,21, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  7, 0, 0};
        vecs[9]  = '{0, 2, 8, 9,22,23, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  9, 0, 0};
        vecs[10] = '{0, 1,10, 0,24, 0, 0, 2, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 10, 0, 0};
        vecs[11] = '{0, 2,11,12,25,26, 3, 0, 0, 1, 5, 0, 1, 1,  0, 0,  0,  0,  0,  0,  7, 1, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0,  0, 20,  0,  7, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 6, 6, 0, 0,  0, 0,  0,  0,  0,  0,  7, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0,  0, 21,  0,  7, 0, 0};
        vecs[15] = '{0, 2, 7, 7,30,31, 3, 0, 0, 0, 0, 0, 1, 0,  0, 0,  0,  0,  0,  0,  9, 0, 0};
        vecs[16] = '{1, 1, 1, 0,50, 0, 1, 0, 0, 0, 0, 0, 0, 0,  3, 3, 21, 30, 30, 31,  9, 0, 0};
        vecs[17] = '{0, 1, 7, 0,40, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 10, 0, 0};
        vecs[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  9, 0, 0};
        vecs[19] = '{0, 1, 7, 0,41, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0,  0,  0,  0,  0, 10, 0, 0};
        vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0, 10, 0, 0};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 9, 0, 0,  0, 0,  0,  0,  0,  0, 10, 0, 0};
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 31,  0, 41,  0, 10, 0, 0};

        idle_in();
        #2;
        check("reset.commit_valid", 32'(rif.commit_valid), 0);
        check("reset.free_valid", 32'(rif.free_valid), 0);
        check("reset.disp_idx", 32'(rif.disp_idx), 32'h10);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            rif.clear          = 1'(vecs[i].clr);
            rif.disp_count     = 2'(vecs[i].dc);
            rif.disp_areg      = {4'(vecs[i].a1), 4'(vecs[i].a0)};
            rif.disp_preg      = {6'(vecs[i].p1), 6'(vecs[i].p0)};
            rif.disp_zerocycle = 2'(vecs[i].zc);
            rif.disp_tag       = {2'(vecs[i].t1), 2'(vecs[i].t0)};
            rif.wb_valid       = 2'(vecs[i].wbv);
            rif.wb_idx         = {4'(vecs[i].w1), 4'(vecs[i].w0)};
            rif.flush_valid    = 1'(vecs[i].fv);
            rif.flush_tag      = 2'(vecs[i].ft);
            tick();
            check($sformatf("v%0d.commit_valid", i), 32'(rif.commit_valid), 32'(vecs[i].cv));
            check($sformatf("v%0d.free_valid", i), 32'(rif.free_valid), 32'(vecs[i].fvl));
            check($sformatf("v%0d.free_addr", i), 32'(rif.free_addr), pk6(vecs[i].fa0, vecs[i].fa1));
            check($sformatf("v%0d.commit_preg", i), 32'(rif.commit_preg), pk6(vecs[i].cp0, vecs[i].cp1));
            check($sformatf("v%0d.disp_idx", i), 32'(rif.disp_idx), didx_pk(vecs[i].didx));
            check($sformatf("v%0d.fl_shootdown", i), 32'(rif.fl_shootdown), 32'(vecs[i].fl));
            check($sformatf("v%0d.fl_tag", i), 32'(rif.fl_shootdown_tag), 32'(vecs[i].flt));
            $display("[TB] vec %0d: cv=%b fv=%b didx=0x%h", i, rif.commit_valid, rif.free_valid, rif.disp_idx);
        end
        idle_in();

        // Asynchronous reset while retirements are in flight.
        disp(2, 3, 0, 0, 1);
        tick();
        tick();
        check("rst_mid.pre_commit", 32'(rif.commit_valid), 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid.commit_valid", 32'(rif.commit_valid), 0);
        check("rst_mid.free_valid", 32'(rif.free_valid), 0);
        check("rst_mid.commit_preg", 32'(rif.commit_preg), 0);
        check("rst_mid.disp_stall", 32'(rif.disp_stall), 0);
        check("rst_mid.disp_idx", 32'(rif.disp_idx), 32'h10);
        idle_in();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check("rst_mid.no_leftover", 32'(rif.commit_valid), 0);
        $display("[TB] reset mid-traffic done");

        // Fill all 16 entries busy, then wrap.
        for (int c = 0; c < 8; c++) begin
            disp(2, 0, 0, 0, 2 * c);
            tick();
        end
        rif.disp_count = 2'd1;
        #1;
        check("full.stall", 32'(rif.disp_stall), 1);
        tick();
        check("full.tail_held", 32'(rif.disp_idx[3:0]), 0);
        idle_in();
        wb2(1, 0, 0);
        tick();
        idle_in();
        tick();
        check("full.commit_idx0", 32'(rif.commit_valid), 32'h1);
        disp(1, 0, 0, 0, 5);
        #1;
        check("wrap.stall_clear", 32'(rif.disp_stall), 0);
        check("wrap.idx0", 32'(rif.disp_idx[3:0]), 0);
        tick();
        check("wrap.next_idx", 32'(rif.disp_idx[3:0]), 1);
        check("wrap.full_again", 32'(rif.disp_stall), 1);
        idle_in();
        $display("[TB] full/wrap done");

        // Squash tags >= 1 among entries tagged 0,0,1,1,2 at idx 4..8.
        do_reset();
        disp(2, 3, 0, 0, 0);
        tick();
        disp(2, 3, 0, 0, 2);
        tick();
        idle_in();
        tick();
        tick();
        disp(2, 0, 0, 0, 4);
        tick();
        disp(2, 0, 1, 1, 6);
        tick();
        disp(1, 0, 2, 0, 8);
        tick();
        check("flush.pre_tail", 32'(rif.disp_idx[3:0]), 9);
        idle_in();
        rif.flush_valid = 1'b1;
        rif.flush_tag   = 2'd1;
        tick();
        idle_in();
        check("flush.tail", 32'(rif.disp_idx[3:0]), 6);
        check("flush.shootdown", 32'(rif.fl_shootdown), 1);
        check("flush.shootdown_tag", 32'(rif.fl_shootdown_tag), 1);
        tick();
        check("flush.pulse_end", 32'(rif.fl_shootdown), 0);
        wb2(3, 4, 5);
        tick();
        idle_in();
        tick();
        check("flush.survivors_commit", 32'(rif.commit_valid), 32'h3);
        wb2(3, 6, 7);
        tick();
        idle_in();
        tick();
        check("flush.squashed_gone", 32'(rif.commit_valid), 0);
        check("flush.empty_tail", 32'(rif.disp_idx[3:0]), 6);
        $display("[TB] flush done");

`ifdef ROB_EXCEPTION_EN
        do_reset();
        disp(2, 0, 0, 0, 1);
        tick();
        disp(1, 0, 0, 0, 3);
        tick();
        idle_in();
        wb2(3, 0, 1);
        tick();
        wb2(1, 2, 0);
        rif.wb_exc = 2'b01;
        tick();
        idle_in();
        check("exc.commit01", 32'(rif.commit_valid), 32'h3);
        tick();
        check("exc.valid", 32'(rif.exc_valid), 1);
        check("exc.idx", 32'(rif.exc_idx), 2);
        check("exc.no_commit", 32'(rif.commit_valid), 0);
        check("exc.tail_at_head", 32'(rif.disp_idx[3:0]), 2);
        tick();
        check("exc.pulse_end", 32'(rif.exc_valid), 0);
        $display("[TB] exception done");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
